// File: rtl/fifo_pop_ctrl_if.sv
// rtl/fifo_pop_ctrl_if.sv - upstream-fifo and downstream handshake bundle for fifo_pop_ctrl
interface fifo_pop_ctrl_if #(
    parameter int DATA_SIZE = 10
);
    logic                 enable;
    logic                 fifo_empty;
    logic                 almost_empty;
    logic                 fifo_error;
    logic [DATA_SIZE-1:0] data_out_pop;
    logic                 read;
    logic [DATA_SIZE-1:0] data_out;
    logic                 valid_out;
    logic                 ready_in;
    logic [15:0]          pop_count;
    logic                 err_flag;

    modport master (
        input  enable, fifo_empty, almost_empty, fifo_error, data_out_pop, ready_in,
        output read, data_out, valid_out, pop_count, err_flag
    );

    modport slave (
        output enable, fifo_empty, almost_empty, fifo_error, data_out_pop, ready_in,
        input  read, data_out, valid_out, pop_count, err_flag
    );
endinterface

// File: rtl/fifo_pop_ctrl.sv
// rtl/fifo_pop_ctrl.sv - drains an upstream fifo into a 2-entry skid buffer with a valid/ready output
module fifo_pop_ctrl #(
    parameter int DATA_SIZE = 10,
    parameter int MAIN_SIZE = 8
) (
    input  logic            clk,
    input  logic            reset,
    fifo_pop_ctrl_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] STOP  = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

    logic [1:0]           state_q, state_d;
    logic                 inflight_q, inflight_d;
    logic [1:0]           occ_q, occ_d;
    logic [DATA_SIZE-1:0] buf0_q, buf0_d;
    logic [DATA_SIZE-1:0] buf1_q, buf1_d;
    logic [15:0]          pop_count_q, pop_count_d;
    logic                 err_flag_q, err_flag_d;

    logic                 deq;
    logic                 read;
    logic [2:0]           committed;

    assign deq       = (occ_q != 2'd0) & bus.ready_in;
    // Words the buffer must still hold after this edge, counting the one already on its way.
    assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, deq};

    // The empty flag upstream lags by a cycle, so near empty only every other cycle may pop.
    assign read = (state_q == RUN) & ~bus.fifo_empty & ~bus.fifo_error
                & (committed < 3'd2) & ~(bus.almost_empty & inflight_q);

    always_comb begin
        state_d = state_q;
        if (bus.fifo_error) begin
            state_d = ERROR;
        end else begin
            case (state_q)
                IDLE:    if (bus.enable) state_d = RUN;
                RUN:     if (!bus.enable) state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = ERROR;
            endcase
        end
    end

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case ({inflight_q, deq})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = bus.data_out_pop;
                else               buf1_d = bus.data_out_pop;
            end
            2'b01: buf0_d = buf1_q;
            2'b11: begin
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = bus.data_out_pop;
                end else begin
                    buf0_d = bus.data_out_pop;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        inflight_d  = read;
        occ_d       = occ_q + {1'b0, inflight_q} - {1'b0, deq};
        pop_count_d = pop_count_q + {15'd0, deq};
        err_flag_d  = err_flag_q | (state_d == ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            pop_count_q <= 16'd0;
            err_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            pop_count_q <= pop_count_d;
            err_flag_q  <= err_flag_d;
        end
    end

    assign bus.read      = read;
    assign bus.data_out  = buf0_q;
    assign bus.valid_out = (occ_q != 2'd0);
    assign bus.pop_count = pop_count_q;
    assign bus.err_flag  = err_flag_q;
endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb/tb_fifo_pop_ctrl.sv - scoreboard bench for fifo_pop_ctrl against an upstream fifo model
module tb_fifo_pop_ctrl;
    localparam int DW = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_pop_ctrl_if #(.DATA_SIZE(DW)) bus ();
    fifo_pop_ctrl #(.DATA_SIZE(DW), .MAIN_SIZE(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pend = '0;
    int            outst_m = 0;
    bit            inflight_m = 1'b0;
    int            mode_m = 0;
    bit            err_m = 1'b0;
    logic [15:0]   cnt_m = 16'd0;
    int            reads_cnt = 0;
    int            first_read = -1;
    int            first_valid = -1;
    int            read_log[$];
    int            deq_log[$];
    bit            ae_mode = 1'b0;
    int            ae_thr = 3;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget, input bit incl_fq);
        int n = 0;
        while ((outst_m != 0 || (incl_fq && fq.size() != 0)) && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain_in_time", n < budget, 1);
    endtask

    // Upstream fifo model plus reference for read/valid/err_flag, sampled mid-cycle.
    initial begin
        bus.fifo_empty   = 1'b1;
        bus.almost_empty = 1'b0;
        bus.data_out_pop = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.fifo_empty   = (fq.size() == 0);
            bus.almost_empty = ae_mode && (fq.size() <= ae_thr);
            bus.data_out_pop = pend;
            @(negedge clk);
            if (reset) begin
                outst_m    = 0;
                inflight_m = 1'b0;
                mode_m     = 0;
                err_m      = 1'b0;
                pend       = '0;
            end else begin
                bit deq;
                bit exp_rd;
                int occ_m;
                deq   = bus.valid_out && bus.ready_in;
                occ_m = outst_m - int'(inflight_m);
                chk("valid_out", bus.valid_out, occ_m > 0);
                chk("err_flag", bus.err_flag, err_m);
                if (inflight_m) chk("buffer_overflow", (occ_m == 2) && !deq, 0);
                exp_rd = (mode_m == 1) && !bus.fifo_empty && !bus.fifo_error
                       && ((outst_m - int'(deq)) < 2) && !(bus.almost_empty && inflight_m);
                chk("read", bus.read, exp_rd);
                if (bus.read) begin
                    chk("fifo_underflow", fq.size() == 0, 0);
                    pend = (fq.size() > 0) ? fq.pop_front() : '0;
                    exp_q.push_back(pend);
                    reads_cnt++;
                    read_log.push_back(cyc);
                    if (first_read < 0) first_read = cyc;
                end
                outst_m    = outst_m - int'(deq) + int'(bus.read);
                inflight_m = bus.read;
                if (bus.fifo_error) begin
                    mode_m = 3;
                    err_m  = 1'b1;
                end else begin
                    case (mode_m)
                        0:       if (bus.enable) mode_m = 1;
                        1:       if (!bus.enable) mode_m = 2;
                        2:       mode_m = 0;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Output monitor: every accepted word is checked against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                cnt_m = 16'd0;
            end else begin
                chk("pop_count", bus.pop_count, cnt_m);
                if (bus.valid_out && first_valid < 0) first_valid = cyc;
                if (bus.valid_out && bus.ready_in) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL data: got %0h expected no word (cycle %0d)", bus.data_out, cyc);
                    end else begin
                        chk("data", bus.data_out, exp_q.pop_front());
                    end
                    cnt_m = cnt_m + 16'd1;
                    deq_log.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset            = 1'b1;
        bus.enable       = 1'b0;
        bus.ready_in     = 1'b0;
        bus.fifo_error   = 1'b0;
        tick(2);
        chk("rst_read", bus.read, 0);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_pop_count", bus.pop_count, 0);
        chk("rst_err", bus.err_flag, 0);
        reset = 1'b0;

        // Eight words at full throughput
        for (int i = 1; i <= 8; i++) fq.push_back(DW'(i));
        first_read = -1;
        first_valid = -1;
        deq_log.delete();
        bus.enable   = 1'b1;
        bus.ready_in = 1'b1;
        drain(60, 1);
        chk("latency", first_valid - first_read, 2);
        chk("deq_count8", deq_log.size(), 8);
        if (deq_log.size() == 8) chk("no_gaps", deq_log[7] - deq_log[0], 7);
        chk("pop_count8", bus.pop_count, 8);

        // Backpressure: only two words may be committed
        bus.ready_in = 1'b0;
        reads_cnt = 0;
        for (int i = 0; i < 5; i++) fq.push_back(DW'(10'h100 + i));
        tick(12);
        chk("bp_reads", reads_cnt, 2);
        chk("bp_valid", bus.valid_out, 1);
        bus.ready_in = 1'b1;
        drain(40, 1);
        chk("bp_reads_total", reads_cnt, 5);
        chk("pop_count13", bus.pop_count, 13);

        // Almost-empty throttle
        ae_mode = 1'b1;
        ae_thr = 3;
        reads_cnt = 0;
        read_log.delete();
        for (int i = 0; i < 3; i++) fq.push_back(DW'(10'h200 + i));
        drain(40, 1);
        chk("ae_reads", reads_cnt, 3);
        for (int k = 1; k < read_log.size(); k++)
            chk("ae_alternate", (read_log[k] - read_log[k-1]) >= 2, 1);

        // Random traffic
        ae_thr = 2;
        repeat (1500) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 8) fq.push_back(DW'($urandom));
            bus.ready_in = ($urandom_range(0, 3) != 0);
            bus.enable   = ($urandom_range(0, 15) != 0);
            tick(1);
        end
        bus.enable   = 1'b1;
        bus.ready_in = 1'b1;
        drain(100, 1);
        chk("rand_scoreboard_empty", exp_q.size(), 0);

        // Error pulse with a word in flight
        ae_mode = 1'b0;
        bus.ready_in = 1'b0;
        for (int i = 0; i < 4; i++) fq.push_back(DW'(10'h300 + i));
        n = 0;
        while (!inflight_m && n < 20) begin
            tick(1);
            n++;
        end
        chk("err_inflight_seen", inflight_m, 1);
        deq_log.delete();
        bus.fifo_error = 1'b1;
        tick(1);
        bus.fifo_error = 1'b0;
        tick(3);
        chk("err_flag_set", bus.err_flag, 1);
        chk("err_no_read", bus.read, 0);
        bus.ready_in = 1'b1;
        drain(20, 0);
        tick(2);
        chk("err_drained", deq_log.size(), 1);
        chk("err_flag_sticky", bus.err_flag, 1);
        chk("err_valid_low", bus.valid_out, 0);
        fq.delete();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("err_cleared", bus.err_flag, 0);

        // pop_count wrap across a RUN->STOP->IDLE drain
        n = 0;
        while (cnt_m != 16'hFFFE && n < 70000) begin
            while (fq.size() < 4) fq.push_back(DW'($urandom));
            tick(1);
            n++;
        end
        chk("pop_count_fffe", bus.pop_count, 16'hFFFE);
        bus.ready_in = 1'b0;
        tick(4);
        bus.enable = 1'b0;
        tick(4);
        chk("stop_no_read", bus.read, 0);
        chk("stop_valid", bus.valid_out, 1);
        bus.ready_in = 1'b1;
        tick(1);
        bus.ready_in = 1'b0;
        chk("pop_count_ffff", bus.pop_count, 16'hFFFF);
        bus.ready_in = 1'b1;
        tick(1);
        chk("pop_count_wrap", bus.pop_count, 16'h0000);
        fq.delete();
        drain(10, 0);

        // Asynchronous reset with a full buffer
        bus.enable = 1'b1;
        for (int i = 0; i < 6; i++) fq.push_back(DW'(10'h3C0 + i));
        tick(8);
        bus.ready_in = 1'b0;
        tick(6);
        chk("pre_rst_valid", bus.valid_out, 1);
        chk("pre_rst_count_nonzero", bus.pop_count != 16'd0, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_valid", bus.valid_out, 0);
        chk("async_pop_count", bus.pop_count, 0);
        chk("async_read", bus.read, 0);
        chk("async_data", bus.data_out, 0);
        tick(2);
        chk("rst_hold_read", bus.read, 0);
        reset = 1'b0;
        bus.ready_in = 1'b1;
        drain(60, 1);
        tick(2);
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
